// File: rtl/rv_id_queue.sv
// Purpose: decode-stage issue queue; decodes fetched instructions on entry, holds 2, issues in order.
// Latency: an entry accepted at edge N is presented to EX in cycle N+1; throughput is 1/cycle.
// Backpressure: if_ready (registered) drops when full; ex_ready=0 holds the head stable; load-use hazard bubbles.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_valid/if_ready/if_instr/if_pc  fetch-side handshake and payload
//   ex_valid/ex_ready                 issue-side handshake
//   ex_instr/ex_pc/ex_imm/ex_fmt/ex_rs1/ex_rs2/ex_rd/ex_illegal  decoded head entry
//   flush                             discard all queued entries
//   ld_valid/ld_rd                    load currently in EX (hazard source)
//   stall_cnt                         saturating count of hazard bubble cycles
// Optional feature: RV_ID_ILLEGAL_TRAP_EN -- illegal opcodes raise ex_illegal and
// block further fetch after they issue, until the next flush.
module rv_id_queue #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [31:0]   if_instr,
    input  logic [DW-1:0] if_pc,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [31:0]   ex_instr,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_imm,
    output logic [2:0]    ex_fmt,
    output logic [4:0]    ex_rs1,
    output logic [4:0]    ex_rs2,
    output logic [4:0]    ex_rd,
    output logic          ex_illegal,
    input  logic          flush,
    input  logic          ld_valid,
    input  logic [4:0]    ld_rd,
    output logic [31:0]   stall_cnt
);

    typedef struct packed {
        logic [31:0]   instr;
        logic [DW-1:0] pc;
        logic [DW-1:0] imm;
        logic [2:0]    fmt;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    // Full decode of one instruction; register fields a format does not use
    // stay 0, which also keeps them out of the hazard compare.
    function automatic entry_t decode(input logic [31:0] in, input logic [DW-1:0] pc);
        entry_t      e;
        logic [31:0] imm32;
        e       = '0;
        imm32   = '0;
        e.instr = in;
        e.pc    = pc;
        case (in[6:0])
            7'b0110011: begin
                e.fmt = 3'd0;
                e.rs1 = in[19:15];
                e.rs2 = in[24:20];
                e.rd  = in[11:7];
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                e.fmt = 3'd1;
                e.rs1 = in[19:15];
                e.rd  = in[11:7];
                imm32 = {{20{in[31]}}, in[31:20]};
            end
            7'b0100011: begin
                e.fmt = 3'd2;
                e.rs1 = in[19:15];
                e.rs2 = in[24:20];
                imm32 = {{20{in[31]}}, in[31:25], in[11:7]};
            end
            7'b1100011: begin
                e.fmt = 3'd3;
                e.rs1 = in[19:15];
                e.rs2 = in[24:20];
                imm32 = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = 3'd4;
                e.rd  = in[11:7];
                imm32 = {in[31:12], 12'b0};
            end
            7'b1101111: begin
                e.fmt = 3'd5;
                e.rd  = in[11:7];
                imm32 = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
            end
            default: e.fmt = 3'd7;
        endcase
        e.imm = DW'($signed(imm32));
        return e;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    entry_t      r_slot [2];
    logic        r_if_ready;
    logic [31:0] r_stall_cnt;

    entry_t      w_head;
    logic        w_not_empty;
    logic        w_hazard;
    logic        w_enq;
    logic        w_deq;
    logic        w_block_nxt;

    assign w_head      = r_slot[r_rd_ptr];
    assign w_not_empty = (r_state != ST_EMPTY);
    assign w_hazard    = ld_valid && (ld_rd != 5'd0) &&
                         ((ld_rd == w_head.rs1) || (ld_rd == w_head.rs2));
    assign ex_valid    = w_not_empty && !w_hazard;
    assign w_deq       = ex_valid && ex_ready;
    assign w_enq       = if_valid && r_if_ready && !flush;

`ifdef RV_ID_ILLEGAL_TRAP_EN
    logic r_block;
    logic w_head_ill;

    assign w_head_ill  = (w_head.fmt == 3'd7);
    // Once an illegal entry has issued, fetch stays closed until the trap flush.
    assign w_block_nxt = !flush && (r_block || (w_deq && w_head_ill));
    assign ex_illegal  = w_head_ill;

    always_ff @(posedge clk) begin
        if (!rst_n) r_block <= 1'b0;
        else        r_block <= w_block_nxt;
    end
`else
    assign w_block_nxt = 1'b0;
    assign ex_illegal  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_enq) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_enq && !w_deq)      w_state_nxt = ST_FULL;
                    else if (!w_enq && w_deq) w_state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (w_deq) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_slot[0]   <= '0;
            r_slot[1]   <= '0;
            r_if_ready  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_if_ready <= (w_state_nxt != ST_FULL) && !w_block_nxt;
            if (flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_enq) r_wr_ptr <= ~r_wr_ptr;
                if (w_deq) r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_enq) r_slot[r_wr_ptr] <= decode(if_instr, if_pc);
            if (w_not_empty && w_hazard && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign if_ready   = r_if_ready;
    assign ex_instr   = w_head.instr;
    assign ex_pc      = w_head.pc;
    assign ex_imm     = w_head.imm;
    assign ex_fmt     = w_head.fmt;
    assign ex_rs1     = w_head.rs1;
    assign ex_rs2     = w_head.rs2;
    assign ex_rd      = w_head.rd;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_rv_id_queue.sv
// Purpose: scoreboard bench for rv_id_queue; stimulus pushes expected decodes, a monitor pops on issue.
// Latency: checks first-issue latency, streaming rate, hazard bubbles, flush and reset behaviour.
// Backpressure: drives ex_ready low to fill the queue and checks if_ready / held outputs.
`timescale 1ns/1ps
module tb_rv_id_queue;

`ifdef RV_ID_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [31:0] ADDI = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] SW   = 32'h0020_A423;  // sw x2,8(x1)
    localparam logic [31:0] LUI  = 32'h1234_52B7;  // lui x5,0x12345
    localparam logic [31:0] BEQ  = 32'hFE00_0EE3;  // beq x0,x0,-4
    localparam logic [31:0] JAL  = 32'h8000_00EF;  // jal x1,-1MiB
    localparam logic [31:0] ADD  = 32'h0020_81B3;  // add x3,x1,x2
    localparam logic [31:0] ILL  = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_instr, ex_pc, ex_imm;
    logic [2:0]  ex_fmt;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_illegal;
    logic        flush, ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    rv_id_queue #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_fmt(ex_fmt), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_illegal(ex_illegal), .flush(flush), .ld_valid(ld_valid), .ld_rd(ld_rd),
        .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   issued = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction; the expected decode is queued at the negedge where
    // the handshake is seen to complete on the following edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [2:0] fmt, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ill, output int waits);
        exp_t e;
        e        = {ins, pc, imm, fmt, rs1, rs2, rd, ill};
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
        waits    = 0;
        @(negedge clk);
        while (!if_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!if_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pc 0x%08h not accepted after %0d cycles", pc, waits);
        end else begin
            exp_q.push_back(e);
        end
        step();
        if_valid = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t a;
        if (rst_n && ex_valid && ex_ready) begin
            issued++;
            checks++;
            a = {ex_instr, ex_pc, ex_imm, ex_fmt, ex_rs1, ex_rs2, ex_rd, ex_illegal};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got instr 0x%08h pc 0x%08h, expected no issue", ex_instr, ex_pc);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL issue_pc%08h: got instr=%08h pc=%08h imm=%08h fmt=%0d rs1=%0d rs2=%0d rd=%0d ill=%0b expected instr=%08h pc=%08h imm=%08h fmt=%0d rs1=%0d rs2=%0d rd=%0d ill=%0b",
                             e.pc, a.instr, a.pc, a.imm, a.fmt, a.rs1, a.rs2, a.rd, a.ill,
                             e.instr, e.pc, e.imm, e.fmt, e.rs1, e.rs2, e.rd, e.ill);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        ex_ready = 1'b0; flush = 1'b0; ld_valid = 1'b0; ld_rd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_ready", if_ready, 0);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_instr", ex_instr, 0);
        check("rst_ex_pc", ex_pc, 0);
        check("rst_ex_imm", ex_imm, 0);
        check("rst_ex_fmt", ex_fmt, 0);
        check("rst_ex_illegal", ex_illegal, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("if_ready_before_edge", if_ready, 0);
        step();
        @(negedge clk);
        check("if_ready_after_edge", if_ready, 1);
        step();

        // Streaming with EX always ready
        ex_ready = 1'b1;
        send(ADDI, 32'h0, 32'd5, 3'd1, 5'd1 - 5'd1, 5'd0, 5'd1, 1'b0, w);
        @(negedge clk);
        check("latency_ex_valid", ex_valid, 1);
        check("latency_ex_pc", ex_pc, 32'h0);
        step();
        send(ADDI, 32'h4, 32'd5, 3'd1, 5'd0, 5'd0, 5'd1, 1'b0, w);
        check("stream_wait_1", w, 0);
        send(ADDI, 32'h8, 32'd5, 3'd1, 5'd0, 5'd0, 5'd1, 1'b0, w);
        check("stream_wait_2", w, 0);
        send(ADDI, 32'hC, 32'd5, 3'd1, 5'd0, 5'd0, 5'd1, 1'b0, w);
        check("stream_wait_3", w, 0);
        repeat (2) step();
        check("issued_after_stream", issued, 4);

        // Backpressure: fill, hold, release
        ex_ready = 1'b0;
        send(SW,  32'h100, 32'd8, 3'd2, 5'd1, 5'd2, 5'd0, 1'b0, w);
        send(LUI, 32'h104, 32'h1234_5000, 3'd4, 5'd0, 5'd0, 5'd5, 1'b0, w);
        @(negedge clk);
        check("full_if_ready", if_ready, 0);
        check("full_ex_valid", ex_valid, 1);
        check("full_head_pc", ex_pc, 32'h100);
        repeat (3) step();
        @(negedge clk);
        check("hold_ex_instr", ex_instr, SW);
        check("hold_ex_imm", ex_imm, 32'd8);
        check("hold_ex_pc", ex_pc, 32'h100);
        step();
        ex_ready = 1'b1;
        send(BEQ, 32'h108, 32'hFFFF_FFFC, 3'd3, 5'd0, 5'd0, 5'd0, 1'b0, w);
        check("refill_wait", w, 1);
        send(JAL, 32'h10C, 32'hFFF0_0000, 3'd5, 5'd0, 5'd0, 5'd1, 1'b0, w);
        repeat (3) step();
        check("issued_after_backpressure", issued, 8);

        // Load-use hazard
        ld_valid = 1'b1; ld_rd = 5'd2;
        send(ADD, 32'h200, 32'd0, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0, w);
        @(negedge clk);
        check("hazard_cycle1_ex_valid", ex_valid, 0);
        step();
        @(negedge clk);
        check("hazard_cycle2_ex_valid", ex_valid, 0);
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        check("hazard_stall_cnt", stall_cnt, 2);
        check("hazard_release_ex_valid", ex_valid, 1);
        step();
        ld_valid = 1'b1; ld_rd = 5'd3;
        send(ADD, 32'h204, 32'd0, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0, w);
        @(negedge clk);
        check("no_hazard_on_rd", ex_valid, 1);
        step();
        ld_rd = 5'd0;
        send(ADD, 32'h208, 32'd0, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0, w);
        @(negedge clk);
        check("no_hazard_ld_rd0", ex_valid, 1);
        step();
        ld_rd = 5'd5;
        send(ADDI, 32'h20C, 32'd5, 3'd1, 5'd0, 5'd0, 5'd1, 1'b0, w);
        @(negedge clk);
        check("no_hazard_unused_rs2", ex_valid, 1);
        step();
        ld_valid = 1'b0; ld_rd = 5'd0;
        step();
        check("stall_cnt_unchanged", stall_cnt, 2);
        check("issued_after_hazard", issued, 12);

        // Flush of a full queue with a simultaneous fetch
        ex_ready = 1'b0;
        send(SW,  32'h300, 32'd8, 3'd2, 5'd1, 5'd2, 5'd0, 1'b0, w);
        send(LUI, 32'h304, 32'h1234_5000, 3'd4, 5'd0, 5'd0, 5'd5, 1'b0, w);
        flush = 1'b1; if_valid = 1'b1; if_instr = ADD; if_pc = 32'h308;
        step();
        flush = 1'b0; if_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_ex_valid", ex_valid, 0);
        check("flush_if_ready", if_ready, 1);
        step();
        ex_ready = 1'b1;
        repeat (2) step();
        check("flush_nothing_issued", issued, 12);
        send(ADDI, 32'h310, 32'd5, 3'd1, 5'd0, 5'd0, 5'd1, 1'b0, w);
        repeat (2) step();
        check("issued_after_flush", issued, 13);

        // Illegal opcode
        send(ILL, 32'h400, 32'd0, 3'd7, 5'd0, 5'd0, 5'd0, TRAP, w);
        @(negedge clk);
        step();
        @(negedge clk);
        check("illegal_if_ready", if_ready, TRAP ? 32'd0 : 32'd1);
        repeat (2) step();
        check("illegal_if_ready_held", if_ready, TRAP ? 32'd0 : 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("if_ready_after_trap_flush", if_ready, 1);
        step();
        send(ADDI, 32'h404, 32'd5, 3'd1, 5'd0, 5'd0, 5'd1, 1'b0, w);
        repeat (2) step();
        check("issued_after_illegal", issued, 15);

        // Reset in the middle of operation
        ex_ready = 1'b0;
        send(ADDI, 32'h500, 32'd5, 3'd1, 5'd0, 5'd0, 5'd1, 1'b0, w);
        send(ADDI, 32'h504, 32'd5, 3'd1, 5'd0, 5'd0, 5'd1, 1'b0, w);
        rst_n = 1'b0;
        step();
        exp_q.delete();
        @(negedge clk);
        check("midrst_if_ready", if_ready, 0);
        check("midrst_ex_valid", ex_valid, 0);
        check("midrst_ex_pc", ex_pc, 0);
        check("midrst_stall_cnt", stall_cnt, 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        ex_ready = 1'b1;
        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 0);
        check("issued_total", issued, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_id_queue.md
# rv_id_queue

Decode-stage issue controller between instruction fetch and execute. Accepts fetched instructions over a valid/ready handshake and decodes each one on entry: format class, register fields and the sign-extended immediate. Holds up to two decoded entries and issues them in order to EX, inserting bubbles on load-use hazards and discarding everything on a pipeline flush. Keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- DW, 32, datapath width of PC and immediate.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- if_valid  in  1  IF presents an instruction.
- if_ready  out  1  ID can accept an instruction (registered).
- if_instr  in  32  instruction word.
- if_pc  in  DW  instruction PC.
- ex_valid  out  1  head entry issuable this cycle.
- ex_ready  in  1  EX accepts the head entry.
- ex_instr  out  32  head instruction word.
- ex_pc  out  DW  head PC.
- ex_imm  out  DW  head sign-extended immediate.
- ex_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- ex_rs1, ex_rs2, ex_rd  out  5 each  register fields (0 when unused by the format).
- ex_illegal  out  1  head opcode unrecognised (see Configuration).
- flush  in  1  kill all queued entries.
- ld_valid  in  1  EX currently holds a load.
- ld_rd  in  5  destination register of that load.
- stall_cnt  out  32  hazard bubble count, saturating.

## Operation
- Opcode map: 0110011 R; 0010011, 0000011, 1100111 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J; all others illegal.
- Immediate: I = sext(in[31:20]); S = sext({in[31:25],in[11:7]}); B = sext({in[31],in[7],in[30:25],in[11:8],0}); U = {in[31:12],12'b0} sign-extended to DW; J = sext({in[31],in[19:12],in[20],in[30:21],0}); R and illegal = 0. Result is truncated or sign-extended to DW.
- Field usage: R/S/B use rs1 and rs2; I uses rs1; U/J use neither. rd is valid for R/I/U/J only. Unused fields are forced to 0.
- Decode is computed at enqueue and stored, so the outputs come straight from the head-slot registers.
- Storage is a 2-slot circular buffer with one-bit read and write pointers. The occupancy FSM has states EMPTY, ONE and FULL.
- Enqueue: if_valid && if_ready && !flush.
- Dequeue: ex_valid && ex_ready.
- FSM transitions:
  - EMPTY→ONE on enqueue.
  - ONE→FULL on enqueue without dequeue.
  - ONE→EMPTY on dequeue without enqueue.
  - ONE→ONE on both.
  - FULL→ONE on dequeue. No enqueue is possible in FULL.
- Hazard: asserted when ld_valid && ld_rd != 0 && (ld_rd == head rs1 || ld_rd == head rs2) for a field used by the head format.
  - ex_valid = !EMPTY && !hazard.
  - Every cycle with !EMPTY && hazard increments stall_cnt, which saturates at 0xFFFFFFFF.
- Flush: the FSM goes to EMPTY and both pointers reset to 0 on the next edge. An if_valid arriving in the flush cycle is dropped. ex_valid may still be 1 in the flush cycle, and a dequeue in that cycle is legal.

## Timing
- Reset (rst_n=0 at an edge):
  - FSM goes to EMPTY and pointers to 0.
  - if_ready=0 and ex_valid=0.
  - All ex_* data outputs = 0.
  - stall_cnt=0.
- Reset mid-operation discards all entries with the same result.
- if_ready is registered as next-state != FULL. It goes to 1 on the first edge after rst_n rises.
- Latency: an instruction enqueued at edge N is on ex_* with ex_valid=1 after edge N (visible in cycle N+1) if no hazard is present.
- Throughput: 1 instruction per cycle while ex_ready=1.
- While ex_valid=1 and ex_ready=0, all ex_* outputs are held stable.
- The hazard check is combinational from ld_valid/ld_rd to ex_valid in the same cycle.

## Configuration
- RV_ID_ILLEGAL_TRAP_EN defined:
  - An illegal opcode yields ex_fmt=7 and ex_illegal=1.
  - When that entry dequeues, if_ready is forced to 0 and stays 0 until flush (the entry blocks further fetch until the trap redirect).
- RV_ID_ILLEGAL_TRAP_EN undefined:
  - ex_illegal is tied to 0.
  - Illegal opcodes issue as fmt=7 with imm=0 and all register fields 0 (a NOP), with no blocking.

## Test plan
- Reset then stream of 0x00500093 (addi x1,x0,5) with ex_ready=1 -> one cycle later ex_valid=1, ex_fmt=1, ex_imm=5, ex_rd=1, ex_rs1=0; one issue per cycle.
- Hold ex_ready=0 and enqueue 3 instructions -> if_ready=0 after 2 accepted; ex_* stable; releasing ex_ready issues them in order.
- Enqueue 0xFE000EE3 (beq x0,x0,-4) -> ex_fmt=3, ex_imm=0xFFFFFFFC; 0x800000EF (jal) -> ex_imm=0xFFF00000.
- Head 0x002081B3 (add x3,x1,x2) with ld_valid=1, ld_rd=2 for 2 cycles -> ex_valid=0 for 2 cycles, stall_cnt=2; ld_rd=0 or ld_valid=0 -> no stall.
- FULL buffer plus flush with if_valid=1 -> EMPTY next cycle, incoming instruction dropped, ex_valid=0, if_ready=1.
- Opcode 0x0000007F -> with RV_ID_ILLEGAL_TRAP_EN: ex_illegal=1, if_ready=0 after it issues until flush; without: ex_illegal=0, ex_imm=0, no block.
